// File: rtl/rgb_block_ctrl.sv
// Block-order read address generator for planar R/G/B pixel memories.
// Define RGB_BLOCK_CTRL_SIZECHK_EN to reject image sizes that are unsupported instead of truncating them.
module rgb_block_ctrl #(
    parameter int ADDR_W = 20,
    parameter int BLK    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       size_x,
    input  logic [31:0]       size_y,
    input  logic              pix_ready,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              pix_valid,
    output logic              finish_64,
    output logic              finish,
    output logic              busy,
    output logic              err
);

    localparam int LOG2 = $clog2(BLK);

    typedef enum logic [1:0] {IDLE, CHECK, RUN, DRAIN} state_t;

    state_t            state, state_next;
    logic [31:0]       sx, sy;
    logic [31:0]       sx_eff, sy_eff;
    logic [31:0]       nbx_last, nby_last;
    logic              size_bad, size_empty;
    logic [LOG2-1:0]   px, py;
    logic [31:0]       bx, by;
    logic [ADDR_W-1:0] addr, row_start, blk_start, blk_row;
    logic [ADDR_W-1:0] stride, blk_stride;
    logic              last_px, last_py, last_bx, last_by, last_pix;
    logic              advance;

`ifdef RGB_BLOCK_CTRL_SIZECHK_EN
    always_comb begin
        sx_eff     = sx;
        sy_eff     = sy;
        size_empty = 1'b0;
        size_bad   = (sx == 32'd0) || (sy == 32'd0) ||
                     (sx[LOG2-1:0] != '0) || (sy[LOG2-1:0] != '0) ||
                     (sx > 32'd1024) || (sy > 32'd1024);
    end

    assign err = (state == CHECK) && size_bad;
`else
    // Sizes are rounded down to whole blocks; a zero-block image completes without reads.
    always_comb begin
        sx_eff     = sx & ~32'(BLK - 1);
        sy_eff     = sy & ~32'(BLK - 1);
        size_bad   = 1'b0;
        size_empty = (sx_eff == 32'd0) || (sy_eff == 32'd0);
    end

    assign err = 1'b0;
`endif

    assign nbx_last   = (sx_eff >> LOG2) - 32'd1;
    assign nby_last   = (sy_eff >> LOG2) - 32'd1;
    assign stride     = ADDR_W'(sx_eff);
    assign blk_stride = ADDR_W'(sx_eff << LOG2);

    assign last_px  = (px == LOG2'(BLK - 1));
    assign last_py  = (py == LOG2'(BLK - 1));
    assign last_bx  = (bx == nbx_last);
    assign last_by  = (by == nby_last);
    assign last_pix = last_px && last_py && last_bx && last_by;
    assign advance  = (state == RUN) && pix_ready;

    assign rd_addr = addr;
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        rd_en      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                if (size_bad) begin
                    state_next = IDLE;
                end else if (size_empty) begin
                    state_next = DRAIN;
                end else begin
                    state_next = RUN;
                end
            end
            RUN: begin
                rd_en = pix_ready;
                if (pix_ready && last_pix) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Scan position and addresses; row and block bases step by adds only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sx        <= '0;
            sy        <= '0;
            px        <= '0;
            py        <= '0;
            bx        <= '0;
            by        <= '0;
            addr      <= '0;
            row_start <= '0;
            blk_start <= '0;
            blk_row   <= '0;
        end else if ((state == IDLE) && start) begin
            sx        <= size_x;
            sy        <= size_y;
            px        <= '0;
            py        <= '0;
            bx        <= '0;
            by        <= '0;
            addr      <= '0;
            row_start <= '0;
            blk_start <= '0;
            blk_row   <= '0;
        end else if (advance) begin
            if (!last_px) begin
                px   <= px + LOG2'(1);
                addr <= addr + ADDR_W'(1);
            end else if (!last_py) begin
                px        <= '0;
                py        <= py + LOG2'(1);
                row_start <= row_start + stride;
                addr      <= row_start + stride;
            end else if (!last_bx) begin
                px        <= '0;
                py        <= '0;
                bx        <= bx + 32'd1;
                blk_start <= blk_start + ADDR_W'(BLK);
                row_start <= blk_start + ADDR_W'(BLK);
                addr      <= blk_start + ADDR_W'(BLK);
            end else if (!last_by) begin
                px        <= '0;
                py        <= '0;
                bx        <= '0;
                by        <= by + 32'd1;
                blk_row   <= blk_row + blk_stride;
                blk_start <= blk_row + blk_stride;
                row_start <= blk_row + blk_stride;
                addr      <= blk_row + blk_stride;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_valid <= 1'b0;
            finish_64 <= 1'b0;
            finish    <= 1'b0;
        end else begin
            pix_valid <= rd_en;
            finish_64 <= rd_en && last_px && last_py;
            finish    <= (rd_en && last_pix) ||
                         ((state == CHECK) && !size_bad && size_empty);
        end
    end

endmodule

// File: tb/tb_rgb_block_ctrl.sv
// Directed self-checking bench for rgb_block_ctrl; addresses are compared against a block-scan model.
module tb_rgb_block_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] size_x;
    logic [31:0] size_y;
    logic        pix_ready;
    logic        rd_en;
    logic [19:0] rd_addr;
    logic        pix_valid;
    logic        finish_64;
    logic        finish;
    logic        busy;
    logic        err;

    int checks   = 0;
    int failures = 0;

    int addrs[$];
    int exp_q[$];
    int n_f64, n_fin, n_pv, last_rd_cyc, fin_cyc, held_bad, extra_rd, extra_fin;
    int timed_out;
    logic fin_with_64, busy_at_fin, busy_after, pv_at_fin;

    rgb_block_ctrl #(.ADDR_W(20), .BLK(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .size_x    (size_x),
        .size_y    (size_y),
        .pix_ready (pix_ready),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .pix_valid (pix_valid),
        .finish_64 (finish_64),
        .finish    (finish),
        .busy      (busy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic build_expected(input int sx, input int sy);
        exp_q.delete();
        for (int by = 0; by < sy / 8; by++)
            for (int bx = 0; bx < sx / 8; bx++)
                for (int py = 0; py < 8; py++)
                    for (int px = 0; px < 8; px++)
                        exp_q.push_back(((by * 8 + py) * sx + bx * 8 + px) & 32'hFFFFF);
    endtask

    task automatic do_start(input int sx, input int sy);
        @(negedge clk);
        start  = 1'b1;
        size_x = sx;
        size_y = sy;
        @(negedge clk);
        start  = 1'b0;
    endtask

    // Records one image run starting from the CHECK cycle, plus four trailing cycles.
    task automatic capture(input int stall_at, input int stall_len, input int start_at, input int max_cyc);
        int  cyc = 0;
        int  left = stall_len;
        bit  done = 0;
        bit  stalled;
        bit  start_sent = 0;
        addrs.delete();
        n_f64 = 0; n_fin = 0; n_pv = 0; last_rd_cyc = -1; fin_cyc = -1;
        held_bad = 0; extra_rd = 0; extra_fin = 0; timed_out = 1;
        fin_with_64 = 0; busy_at_fin = 0; busy_after = 1; pv_at_fin = 0;
        while (cyc < max_cyc && !done) begin
            @(negedge clk);
            stalled = 0;
            start   = 1'b0;
            if (addrs.size() == stall_at && left > 0) begin
                pix_ready = 1'b0;
                left--;
                stalled = 1;
            end else begin
                pix_ready = 1'b1;
            end
            if (addrs.size() == start_at && !start_sent) begin
                start = 1'b1;
                start_sent = 1;
            end
            #1;
            if (stalled && (rd_en !== 1'b0 || rd_addr !== 20'(stall_at))) held_bad++;
            if (rd_en === 1'b1) begin
                addrs.push_back(int'(rd_addr));
                last_rd_cyc = cyc;
            end
            if (pix_valid === 1'b1) n_pv++;
            if (finish_64 === 1'b1) n_f64++;
            if (finish === 1'b1) begin
                n_fin++;
                fin_cyc     = cyc;
                fin_with_64 = finish_64;
                busy_at_fin = busy;
                pv_at_fin   = pix_valid;
                done        = 1;
                timed_out   = 0;
            end
            cyc++;
        end
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pix_ready = 1'b1;
            #1;
            if (i == 0) busy_after = busy;
            if (rd_en === 1'b1) extra_rd++;
            if (finish === 1'b1) extra_fin++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if ({rd_en, rd_addr, pix_valid, finish_64, finish, busy, err} !== 26'd0) begin
            failures++;
            $display("[TB] FAIL reset_outputs actual=%b expected=0",
                     {rd_en, rd_addr, pix_valid, finish_64, finish, busy, err});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic_8x8;
        int bad = 0;
        do_start(8, 8);
        #1;
        checks++;
        if (busy !== 1'b1 || rd_en !== 1'b0) begin
            failures++;
            $display("[TB] FAIL check_cycle busy=%b rd_en=%b expected busy=1 rd_en=0", busy, rd_en);
        end
        capture(-1, 0, -1, 200);
        build_expected(8, 8);
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= addrs.size() || addrs[i] !== exp_q[i]) bad++;
        checks++;
        if (addrs.size() != 64 || bad != 0) begin
            failures++;
            $display("[TB] FAIL basic_addr_seq reads=%0d mismatches=%0d expected reads=64 mismatches=0", addrs.size(), bad);
        end
        checks++;
        if (timed_out != 0 || fin_cyc != last_rd_cyc + 1 || fin_with_64 !== 1'b1 || pv_at_fin !== 1'b1) begin
            failures++;
            $display("[TB] FAIL basic_finish timeout=%0d fin_cyc=%0d last_rd=%0d f64=%b pv=%b expected fin one after last read with f64,pv",
                     timed_out, fin_cyc, last_rd_cyc, fin_with_64, pv_at_fin);
        end
        checks++;
        if (n_f64 != 1 || n_pv != 64) begin
            failures++;
            $display("[TB] FAIL basic_counts f64=%0d pv=%0d expected f64=1 pv=64", n_f64, n_pv);
        end
        checks++;
        if (busy_at_fin !== 1'b1 || busy_after !== 1'b0) begin
            failures++;
            $display("[TB] FAIL basic_busy at_fin=%b after=%b expected 1/0", busy_at_fin, busy_after);
        end
    endtask

    task automatic test_two_blocks_16x8;
        int bad = 0;
        do_start(16, 8);
        capture(-1, 0, -1, 300);
        build_expected(16, 8);
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= addrs.size() || addrs[i] !== exp_q[i]) bad++;
        checks++;
        if (addrs.size() != 128 || bad != 0 || addrs[8] !== 16 || addrs[64] !== 8) begin
            failures++;
            $display("[TB] FAIL blk16x8_addr_seq reads=%0d mismatches=%0d expected reads=128 mismatches=0", addrs.size(), bad);
        end
        checks++;
        if (n_f64 != 2 || n_fin != 1 || fin_with_64 !== 1'b1) begin
            failures++;
            $display("[TB] FAIL blk16x8_pulses f64=%0d fin=%0d fin_with_64=%b expected 2/1/1", n_f64, n_fin, fin_with_64);
        end
    endtask

    task automatic test_stall;
        int bad = 0;
        do_start(8, 8);
        capture(11, 3, -1, 200);
        build_expected(8, 8);
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= addrs.size() || addrs[i] !== exp_q[i]) bad++;
        checks++;
        if (held_bad != 0) begin
            failures++;
            $display("[TB] FAIL stall_hold bad_cycles=%0d expected 0 (rd_en=0 rd_addr=11)", held_bad);
        end
        checks++;
        if (addrs.size() != 64 || bad != 0 || fin_cyc != last_rd_cyc + 1) begin
            failures++;
            $display("[TB] FAIL stall_addr_seq reads=%0d mismatches=%0d fin_cyc=%0d expected 64/0/%0d",
                     addrs.size(), bad, fin_cyc, last_rd_cyc + 1);
        end
    endtask

    task automatic test_size_12;
`ifdef RGB_BLOCK_CTRL_SIZECHK_EN
        int errs = 0;
        int rds  = 0;
        do_start(12, 8);
        #1;
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("[TB] FAIL size12_err actual=%b expected=1", err);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            pix_ready = 1'b1;
            #1;
            if (err === 1'b1) errs++;
            if (rd_en === 1'b1) rds++;
        end
        checks++;
        if (errs != 0 || rds != 0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL size12_after err_cycles=%0d reads=%0d busy=%b expected 0/0/0", errs, rds, busy);
        end
`else
        int bad = 0;
        do_start(12, 8);
        #1;
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL size12_err actual=%b expected=0", err);
        end
        capture(-1, 0, -1, 200);
        build_expected(8, 8);
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= addrs.size() || addrs[i] !== exp_q[i]) bad++;
        checks++;
        if (addrs.size() != 64 || bad != 0 || n_fin != 1) begin
            failures++;
            $display("[TB] FAIL size12_seq reads=%0d mismatches=%0d fin=%0d expected 64/0/1", addrs.size(), bad, n_fin);
        end
`endif
    endtask

    task automatic test_zero_size;
`ifdef RGB_BLOCK_CTRL_SIZECHK_EN
        do_start(0, 8);
        #1;
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("[TB] FAIL zero_err actual=%b expected=1", err);
        end
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || rd_en !== 1'b0 || finish !== 1'b0) begin
            failures++;
            $display("[TB] FAIL zero_after busy=%b rd_en=%b finish=%b expected 0/0/0", busy, rd_en, finish);
        end
`else
        do_start(7, 8);
        capture(-1, 0, -1, 20);
        checks++;
        if (timed_out != 0 || n_fin != 1 || addrs.size() != 0 || pv_at_fin !== 1'b0 || busy_after !== 1'b0) begin
            failures++;
            $display("[TB] FAIL zero_finish timeout=%0d fin=%0d reads=%0d pv=%b busy_after=%b expected 0/1/0/0/0",
                     timed_out, n_fin, addrs.size(), pv_at_fin, busy_after);
        end
`endif
    endtask

    task automatic test_reset_mid_run;
        int cnt = 0;
        int cyc = 0;
        do_start(8, 8);
        while (cnt < 20 && cyc < 100) begin
            @(negedge clk);
            pix_ready = 1'b1;
            #1;
            if (rd_en === 1'b1) cnt++;
            cyc++;
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (cnt != 20 || {rd_en, rd_addr, pix_valid, finish_64, finish, busy, err} !== 26'd0) begin
            failures++;
            $display("[TB] FAIL mid_reset reads=%0d outputs=%b expected 20 reads and all zero",
                     cnt, {rd_en, rd_addr, pix_valid, finish_64, finish, busy, err});
        end
        @(negedge clk);
        rst = 1'b0;
        do_start(8, 8);
        capture(-1, 0, -1, 200);
        checks++;
        if (addrs.size() != 64 || addrs[0] !== 0 || addrs[63] !== 63) begin
            failures++;
            $display("[TB] FAIL restart_addr reads=%0d first=%0d expected 64 reads first=0",
                     addrs.size(), (addrs.size() > 0) ? addrs[0] : -1);
        end
    endtask

    task automatic test_start_during_run;
        int bad = 0;
        do_start(8, 16);
        capture(-1, 0, 30, 300);
        build_expected(8, 16);
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= addrs.size() || addrs[i] !== exp_q[i]) bad++;
        checks++;
        if (addrs.size() != 128 || bad != 0) begin
            failures++;
            $display("[TB] FAIL busy_start_seq reads=%0d mismatches=%0d expected 128/0", addrs.size(), bad);
        end
        checks++;
        if (n_fin != 1 || extra_fin != 0 || extra_rd != 0 || n_f64 != 2) begin
            failures++;
            $display("[TB] FAIL busy_start_finish fin=%0d extra_fin=%0d extra_rd=%0d f64=%0d expected 1/0/0/2",
                     n_fin, extra_fin, extra_rd, n_f64);
        end
    endtask

    task automatic test_back_to_back;
        int bad = 0;
        do_start(16, 16);
        capture(-1, 0, -1, 400);
        build_expected(16, 16);
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= addrs.size() || addrs[i] !== exp_q[i]) bad++;
        checks++;
        if (addrs.size() != 256 || bad != 0 || n_f64 != 4 || addrs[128] !== 128 || addrs[192] !== 136) begin
            failures++;
            $display("[TB] FAIL b2b_16x16 reads=%0d mismatches=%0d f64=%0d expected 256/0/4", addrs.size(), bad, n_f64);
        end
        do_start(8, 8);
        capture(-1, 0, -1, 200);
        checks++;
        if (addrs.size() != 64 || addrs[0] !== 0 || addrs[63] !== 63 || n_fin != 1) begin
            failures++;
            $display("[TB] FAIL b2b_second reads=%0d fin=%0d expected 64/1", addrs.size(), n_fin);
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        size_x    = '0;
        size_y    = '0;
        pix_ready = 1'b0;
        test_reset();
        test_basic_8x8();
        test_two_blocks_16x8();
        test_stall();
        test_size_12();
        test_zero_size();
        test_reset_mid_run();
        test_start_during_run();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rgb_block_ctrl.md
RGB_BLOCK_CTRL -- requirements
Module: rgb_block_ctrl

Interface
REQ-001 Parameter: ADDR_W, 20, pixel memory address width (1M-entry R/G/B planes).
REQ-002 Parameter: BLK, 8, block edge in pixels (BLK x BLK = 64-pixel block).
REQ-003 Port: clk  input  1  sole clock, all state on rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: start  input  1  one-cycle request to begin reading one image.
REQ-006 Port: size_x  input  32  image width in pixels, sampled on accepted start.
REQ-007 Port: size_y  input  32  image height in pixels, sampled on accepted start.
REQ-008 Port: pix_ready  input  1  downstream can accept a pixel this cycle.
REQ-009 Port: rd_en  output  1  read strobe to the R/G/B memory.
REQ-010 Port: rd_addr  output  ADDR_W  pixel address for the current rd_en.
REQ-011 Port: pix_valid  output  1  memory data valid; rd_en delayed one cycle.
REQ-012 Port: finish_64  output  1  pulse with pix_valid of the 64th pixel of each block.
REQ-013 Port: finish  output  1  pulse with pix_valid of the last pixel of the image.
REQ-014 Port: busy  output  1  high from accepted start until the cycle after finish.
REQ-015 Port: err  output  1  one-cycle pulse on rejected image size.

Function
REQ-016 States: IDLE, CHECK, RUN, DRAIN; reset state IDLE.
REQ-017 IDLE: start=1 -> latch sizes, go CHECK; start while busy is ignored.
REQ-018 CHECK (1 cycle): valid size -> RUN; invalid -> pulse err, go IDLE, no rd_en.
REQ-019 Scan order: pixels raster within block (px 0..7, then py 0..7); blocks left-to-right, then top-to-bottom.
REQ-020 rd_addr = (by*BLK+py)*size_x + bx*BLK+px, computed by incremental row-base adders; no multiplier.
REQ-021 RUN: rd_en = pix_ready; address advances only on cycles with rd_en=1.
REQ-022 pix_ready=0: rd_en=0, rd_addr and scan counters held; no address skipped or repeated.
REQ-023 After the last address issues, go DRAIN; DRAIN lasts one cycle (final pix_valid/finish), then IDLE.
REQ-024 finish_64 and finish coincide on the last pixel of the last block.
REQ-025 Address arithmetic ADDR_W bits wide; upper bits of row-base truncated.

Reset
REQ-026 rst=1 forces IDLE immediately; rd_en, rd_addr, pix_valid, finish_64, finish, busy, err, all counters = 0.
REQ-027 Reset mid-RUN abandons the image; the next start restarts at address 0.

Configuration
REQ-028 Macro RGB_BLOCK_CTRL_SIZECHK_EN defined: size invalid if size_x or size_y is 0, not a multiple of BLK, or greater than 1024 -> err pulse.
REQ-029 Macro undefined: low log2(BLK) bits of sizes ignored (truncate to multiple of BLK), size 0 after truncation finishes immediately (finish pulse, no rd_en), err tied 0.

Verification
REQ-030 8x8 image, pix_ready=1: 64 consecutive rd_en, addresses 0..63; finish_64 and finish together one cycle after address 63.
REQ-031 16x8 image: block 0 addresses 0-7,16-23,...,112-119; block 1 addresses 8-15,...,120-127; two finish_64 pulses, finish with second.
REQ-032 8x8, pix_ready low for 3 cycles after address 10: rd_en=0 and rd_addr=11 held 3 cycles, then 11..63 in order.
REQ-033 size_x=12 with macro: err=1 for one cycle, rd_en never asserted; without macro: treated as 8, 64 reads.
REQ-034 rst after 20 reads: all outputs 0 same cycle; new start -> first rd_addr=0.
REQ-035 start pulsed during RUN: ignored, address sequence unchanged, single finish.
